// File: rtl/mano_cache_pkg.sv
// Shared types and constants for the MANO direct-mapped write-through cache.
package mano_cache_pkg;

    localparam int unsigned CACHE_ADDR_W = 12;
    localparam int unsigned CACHE_DATA_W = 16;
    localparam int unsigned CACHE_IDX_W  = 4;
    localparam int unsigned CNT_W        = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU,
        WR_DONE
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// One-word-per-line storage: async read, sync single-port write; only valid bits reset.
module cache_line_array #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents are meaningless until their valid bit is set.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/mano_cache.sv
// Direct-mapped, write-through, no-write-allocate cache in front of slow MANO main memory.
module mano_cache
    import mano_cache_pkg::*;
#(
    parameter int unsigned ADDR_W = CACHE_ADDR_W,
    parameter int unsigned DATA_W = CACHE_DATA_W,
    parameter int unsigned IDX_W  = CACHE_IDX_W
) (
    input  logic              mclk,
    input  logic              mrst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cache_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int unsigned TAG_W = ADDR_W - IDX_W;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic              lookup_hit;
    logic              line_we;
    logic [DATA_W-1:0] line_wdata;

    assign idx        = cpu_addr[IDX_W-1:0];
    assign tag        = cpu_addr[ADDR_W-1:IDX_W];
    assign lookup_hit = line_valid && (line_tag == tag);

    cache_line_array #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_lines (
        .clk      (mclk),
        .rst      (mrst),
        .rd_idx   (idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (cpu_rdata),
        .we       (line_we),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_data  (line_wdata)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        cache_hit   = 1'b1;
        line_we     = 1'b0;
        line_wdata  = cpu_wdata;

        unique case (state_q)
            IDLE: begin
                // A simultaneous read and write is treated as a write.
                if (cpu_wr) begin
                    cache_hit   = 1'b0;
                    state_d     = WR_THRU;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                end else if (cpu_rd) begin
                    if (lookup_hit) begin
                        hit_cnt_d = sat_inc(hit_cnt_q);
                    end else begin
                        cache_hit  = 1'b0;
                        miss_cnt_d = sat_inc(miss_cnt_q);
                        state_d    = RD_MISS;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = cpu_addr;
                    end
                end
            end
            RD_MISS: begin
                cache_hit  = 1'b0;
                line_wdata = mem_rdata;
                if (mem_ack) begin
                    line_we   = 1'b1;
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            WR_THRU: begin
                cache_hit = 1'b0;
                if (mem_ack) begin
                    line_we   = lookup_hit;
                    state_d   = WR_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            WR_DONE: begin
                // One released cycle so the held write is not reissued.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule
